// File: rtl/dsdmnist_pkg.sv
// Shared widths, layer scale constants and the round/clip helper for the requantiser.
package dsdmnist_pkg;

    localparam int unsigned ACC_W  = 25;
    localparam int unsigned K_W    = 33;
    localparam int unsigned FRAC   = 32;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned NCH    = 16;
    localparam int unsigned CH_W   = $clog2(NCH);

    // Product, rounding-sum and rounded-result widths.
    localparam int unsigned PROD_W = ACC_W + K_W;
    localparam int unsigned RND_W  = PROD_W + 1;
    localparam int unsigned R_W    = RND_W - FRAC;

    // Layer scale constants, signed Q1.32.
    localparam logic signed [K_W-1:0] K1 = 33'sh0_00A3_E3B6;
    localparam logic signed [K_W-1:0] K2 = 33'sh0_0230_FB0F;

    // Half an LSB of the output scale, added before the arithmetic shift.
    localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(64'd1 << (FRAC - 1));

    // Clip bounds held at the full rounded width.
    localparam logic signed [R_W-1:0] S_HI = R_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [R_W-1:0] S_LO = R_W'(-(2 ** (OUT_W - 1)));
    localparam logic signed [R_W-1:0] U_HI = R_W'(2 ** OUT_W - 1);
    localparam logic signed [R_W-1:0] U_LO = '0;

    // Requantised result plus its clip flag.
    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] res;
    } rc_t;

    // Round half toward +inf, then saturate to the selected signed/unsigned range.
    function automatic rc_t round_clip(input logic signed [PROD_W-1:0] prod,
                                       input logic                     signed_out);
        logic signed [RND_W-1:0] sum;
        logic signed [R_W-1:0]   r;
        logic signed [R_W-1:0]   hi;
        logic signed [R_W-1:0]   lo;
        rc_t                     rc;
        sum    = $signed({prod[PROD_W-1], prod}) + RND_HALF;
        r      = R_W'(sum >>> FRAC);
        hi     = signed_out ? S_HI : U_HI;
        lo     = signed_out ? S_LO : U_LO;
        rc.sat = 1'b0;
        rc.res = OUT_W'(r);
        if (r > hi) begin
            rc.sat = 1'b1;
            rc.res = OUT_W'(hi);
        end else if (r < lo) begin
            rc.sat = 1'b1;
            rc.res = OUT_W'(lo);
        end
        return rc;
    endfunction

endpackage

// File: rtl/dsdmnist_ktable.sv
// Per-channel scale constant register file: one write port, asynchronous read.
module dsdmnist_ktable #(
    parameter  int unsigned K_W  = dsdmnist_pkg::K_W,
    parameter  int unsigned NCH  = dsdmnist_pkg::NCH,
    localparam int unsigned CH_W = $clog2(NCH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wr_i,
    input  logic [CH_W-1:0] waddr_i,
    input  logic [K_W-1:0]  wdata_i,
    input  logic [CH_W-1:0] raddr_i,
    output logic [K_W-1:0]  rd_data_c
);

    logic [K_W-1:0] tbl_q [NCH];

    // Entry update at the clock edge; a same-cycle reader still sees the old value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_i) begin
            tbl_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational lookup for the sample entering S1.
    always_comb begin
        rd_data_c = tbl_q[raddr_i];
    end

endmodule

// File: rtl/dsdmnist_requant.sv
// Three-stage requantiser: ReLU + constant lookup, signed multiply, round + clip.
module dsdmnist_requant #(
    parameter  int unsigned ACC_W = dsdmnist_pkg::ACC_W,
    parameter  int unsigned K_W   = dsdmnist_pkg::K_W,
    parameter  int unsigned FRAC  = dsdmnist_pkg::FRAC,
    parameter  int unsigned OUT_W = dsdmnist_pkg::OUT_W,
    parameter  int unsigned NCH   = dsdmnist_pkg::NCH,
    localparam int unsigned CH_W  = $clog2(NCH)
) (
    input  logic                    i_CLK,
    input  logic                    i_RST_n,
    input  logic                    i_K_WR,
    input  logic [CH_W-1:0]         i_K_ADDR,
    input  logic [K_W-1:0]          i_K_DATA,
    input  logic                    i_RELU_EN,
    input  logic                    i_SIGNED_OUT,
    input  logic                    i_VALID,
    output logic                    o_READY,
    input  logic signed [ACC_W-1:0] i_ACC,
    input  logic [CH_W-1:0]         i_CH,
    output logic                    o_VALID,
    input  logic                    i_READY,
    output logic [OUT_W-1:0]        o_RESULT,
    output logic                    o_SAT
);

    localparam int unsigned PROD_W = ACC_W + K_W;

    // Global advance: every stage moves when the output slot is empty or draining.
    logic adv_c;

    logic [K_W-1:0]          k_rd_c;
    logic signed [ACC_W-1:0] s1_acc_d;

    logic                    s1_valid_q;
    logic signed [ACC_W-1:0] s1_acc_q;
    logic signed [K_W-1:0]   s1_k_q;
    logic                    s1_signed_q;

    logic signed [PROD_W-1:0] s2_prod_d;
    logic                     s2_valid_q;
    logic signed [PROD_W-1:0] s2_prod_q;
    logic                     s2_signed_q;

    dsdmnist_pkg::rc_t rc_c;

    logic                    out_valid_q;
    logic [OUT_W-1:0]        result_q;
    logic                    sat_q;

    // Advance enable and upstream ready.
    always_comb begin
        adv_c   = ~out_valid_q | i_READY;
        o_READY = adv_c;
    end

    dsdmnist_ktable #(
        .K_W (K_W),
        .NCH (NCH)
    ) u_ktable (
        .clk_i     (i_CLK),
        .rst_ni    (i_RST_n),
        .wr_i      (i_K_WR),
        .waddr_i   (i_K_ADDR),
        .wdata_i   (i_K_DATA),
        .raddr_i   (i_CH),
        .rd_data_c (k_rd_c)
    );

    // ReLU on the incoming accumulator.
    always_comb begin
        s1_acc_d = i_ACC;
        if (i_RELU_EN && i_ACC[ACC_W-1]) begin
            s1_acc_d = '0;
        end
    end

    // S1: capture the ReLU'd accumulator, its constant and the output mode.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            s1_valid_q  <= 1'b0;
            s1_acc_q    <= '0;
            s1_k_q      <= '0;
            s1_signed_q <= 1'b0;
        end else if (adv_c) begin
            s1_valid_q <= i_VALID;
            if (i_VALID) begin
                s1_acc_q    <= s1_acc_d;
                s1_k_q      <= $signed(k_rd_c);
                s1_signed_q <= i_SIGNED_OUT;
            end
        end
    end

    // Full-width signed product; cannot overflow PROD_W.
    always_comb begin
        s2_prod_d = PROD_W'(s1_acc_q) * PROD_W'(s1_k_q);
    end

    // S2: product register, mode travels alongside.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_signed_q <= 1'b0;
        end else if (adv_c) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_q   <= s2_prod_d;
                s2_signed_q <= s1_signed_q;
            end
        end
    end

    // Round and clip the S2 product.
    always_comb begin
        rc_c = dsdmnist_pkg::round_clip(s2_prod_q, s2_signed_q);
    end

    // S3: output register; bubbles load zero so o_RESULT/o_SAT are clean when idle.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
        end else if (adv_c) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                result_q <= rc_c.res;
                sat_q    <= rc_c.sat;
            end else begin
                result_q <= '0;
                sat_q    <= 1'b0;
            end
        end
    end

    // Output drive.
    always_comb begin
        o_VALID  = out_valid_q;
        o_RESULT = result_q;
        o_SAT    = sat_q;
    end

endmodule

// File: tb/tb_dsdmnist_requant.sv
// Self-checking bench for dsdmnist_requant: vector table + queue scoreboard.
module tb_dsdmnist_requant;
    import dsdmnist_pkg::*;

    typedef struct {
        logic                    relu;
        logic                    sgn;
        logic signed [ACC_W-1:0] acc;
        logic [CH_W-1:0]         ch;
        logic [OUT_W-1:0]        er;
        logic                    es;
    } vec_t;

    logic                    clk;
    logic                    rst_n;
    logic                    k_wr;
    logic [CH_W-1:0]         k_addr;
    logic [K_W-1:0]          k_data;
    logic                    relu_en;
    logic                    signed_out;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] acc;
    logic [CH_W-1:0]         ch;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        result;
    logic                    sat;

    int checks;
    int errors;

    rc_t             sb_q[$];
    logic            mv[3];
    logic            hold_pending;
    logic [OUT_W-1:0] hold_res;
    logic            hold_sat;
    logic signed [K_W-1:0] kmodel[NCH];
    logic            saw_not_ready;

    dsdmnist_requant dut (
        .i_CLK        (clk),
        .i_RST_n      (rst_n),
        .i_K_WR       (k_wr),
        .i_K_ADDR     (k_addr),
        .i_K_DATA     (k_data),
        .i_RELU_EN    (relu_en),
        .i_SIGNED_OUT (signed_out),
        .i_VALID      (in_valid),
        .o_READY      (in_ready),
        .i_ACC        (acc),
        .i_CH         (ch),
        .o_VALID      (out_valid),
        .i_READY      (out_ready),
        .o_RESULT     (result),
        .o_SAT        (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ReLU, multiply by the bench's own copy of the table, round/clip.
    function automatic rc_t model(input logic relu, input logic sgn,
                                  input logic signed [ACC_W-1:0] a,
                                  input logic [CH_W-1:0] c);
        logic signed [ACC_W-1:0]  x;
        logic signed [PROD_W-1:0] p;
        x = (relu && a < 0) ? '0 : a;
        p = $signed(x) * $signed(kmodel[c]);
        return round_clip(p, sgn);
    endfunction

    function automatic vec_t mkvec(input logic relu, input logic sgn,
                                   input logic signed [ACC_W-1:0] a,
                                   input logic [CH_W-1:0] c);
        vec_t v;
        rc_t  r;
        r = model(relu, sgn, a, c);
        v = '{relu, sgn, a, c, r.res, r.sat};
        return v;
    endfunction

    // One clock: drive at negedge, check outputs against the shadow pipe, score transfers.
    task automatic tick(input logic v, input vec_t s, input logic rdy,
                        input logic kw, input logic [CH_W-1:0] ka, input logic [K_W-1:0] kd,
                        output logic accepted);
        logic adv;
        rc_t  got;
        rc_t  exp;
        @(negedge clk);
        in_valid   = v;
        acc        = s.acc;
        ch         = s.ch;
        relu_en    = s.relu;
        signed_out = s.sgn;
        out_ready  = rdy;
        k_wr       = kw;
        k_addr     = ka;
        k_data     = kd;
        #1;
        adv = !mv[2] || rdy;
        chk("o_VALID", 64'(out_valid), 64'(mv[2]));
        chk("o_READY", 64'(in_ready), 64'(adv));
        if (!in_ready) saw_not_ready = 1'b1;
        if (hold_pending) begin
            chk("held_result", 64'(result), 64'(hold_res));
            chk("held_sat", 64'(sat), 64'(hold_sat));
        end
        if (mv[2] && rdy) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 64'(1), 64'(0));
            end else begin
                exp = sb_q.pop_front();
                got = '{sat, result};
                chk("result", 64'(got.res), 64'(exp.res));
                chk("sat", 64'(got.sat), 64'(exp.sat));
            end
        end
        hold_pending = mv[2] && !rdy;
        hold_res     = result;
        hold_sat     = sat;
        accepted     = v && adv;
        if (adv) begin
            mv[2] = mv[1];
            mv[1] = mv[0];
            mv[0] = v;
            if (v) sb_q.push_back('{s.es, s.er});
        end
        if (kw) kmodel[ka] = $signed(kd);
    endtask

    vec_t idle_v;

    task automatic kwrite(input logic [CH_W-1:0] a, input logic [K_W-1:0] d);
        logic acc_f;
        tick(1'b0, idle_v, 1'b1, 1'b1, a, d, acc_f);
    endtask

    task automatic drain(input int n);
        logic acc_f;
        for (int i = 0; i < n; i++) tick(1'b0, idle_v, 1'b1, 1'b0, '0, '0, acc_f);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic clear_model();
        sb_q.delete();
        for (int i = 0; i < 3; i++) mv[i] = 1'b0;
        for (int i = 0; i < int'(NCH); i++) kmodel[i] = '0;
        hold_pending = 1'b0;
    endtask

    vec_t tv[9];

    initial begin
        logic acc_f;
        int   sent;
        int   cyc;
        vec_t s;

        checks = 0;
        errors = 0;
        idle_v = '{1'b0, 1'b0, '0, '0, '0, 1'b0};
        rst_n = 1'b0; k_wr = 1'b0; k_addr = '0; k_data = '0; relu_en = 1'b0;
        signed_out = 1'b0; in_valid = 1'b0; acc = '0; ch = '0; out_ready = 1'b1;
        saw_not_ready = 1'b0;
        clear_model();

        // Vectors on ch0 loaded with K1.
        tv[0] = '{1'b1, 1'b0, 25'sd1000,      '0, 8'd3,   1'b0};
        tv[1] = '{1'b1, 1'b0, 25'sd50800,     '0, 8'd127, 1'b0};
        tv[2] = '{1'b1, 1'b0, 25'sd60000,     '0, 8'd150, 1'b0};
        tv[3] = '{1'b1, 1'b1, 25'sd60000,     '0, 8'd127, 1'b1};
        tv[4] = '{1'b1, 1'b1, -25'sd1000,     '0, 8'd0,   1'b0};
        tv[5] = '{1'b0, 1'b1, -25'sd1000,     '0, 8'hFD,  1'b0};
        tv[6] = '{1'b0, 1'b1, -25'sd12744704, '0, 8'h80,  1'b1};
        tv[7] = '{1'b0, 1'b0, -25'sd1000,     '0, 8'd0,   1'b1};
        tv[8] = '{1'b1, 1'b0, 25'sd200000,    '0, 8'd255, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_VALID", 64'(out_valid), 64'(0));
        chk("rst_o_RESULT", 64'(result), 64'(0));
        chk("rst_o_SAT", 64'(sat), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_o_READY", 64'(in_ready), 64'(1));

        kwrite('0, K1);
        for (int i = 0; i < 9; i++) tick(1'b1, tv[i], 1'b1, 1'b0, '0, '0, acc_f);
        drain(5);

        // Alternating channels; a ch1 write coinciding with a ch1 sample.
        kwrite(4'd1, K2);
        for (int i = 0; i < 7; i++) begin
            s = '{1'b1, 1'b0, 25'sd1000, CH_W'(i % 2), ((i % 2) != 0) ? 8'd9 : 8'd3, 1'b0};
            if (i == 6) s.er = 8'd3;
            tick(1'b1, s, 1'b1, (i == 5), 4'd1, K1, acc_f);
        end
        drain(5);
        kwrite(4'd1, K2);

        // Backpressure: five stalled cycles mid-stream.
        sent = 0;
        cyc  = 0;
        saw_not_ready = 1'b0;
        while (sent < 8 && cyc < 100) begin
            s = mkvec(1'b1, 1'b0, ACC_W'(1000 + sent * 7000), '0);
            tick(1'b1, s, !(cyc >= 4 && cyc < 9), 1'b0, '0, '0, acc_f);
            if (acc_f) sent++;
            cyc++;
        end
        chk("bp_all_sent", 64'(sent), 64'(8));
        chk("bp_ready_dropped", 64'(saw_not_ready), 64'(1));
        drain(6);

        // Random traffic with random modes, stalls, bubbles and table writes.
        sent = 0;
        cyc  = 0;
        while (sent < 40 && cyc < 1000) begin
            s = mkvec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ACC_W'(int'($urandom_range(0, 140000)) - 70000),
                      CH_W'($urandom_range(0, 1)));
            tick($urandom_range(0, 3) != 0, s, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, CH_W'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? K1 : K2, acc_f);
            if (acc_f) sent++;
            cyc++;
        end
        chk("rand_all_sent", 64'(sent), 64'(40));
        drain(6);

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) tick(1'b1, tv[i], 1'b1, 1'b0, '0, '0, acc_f);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_o_VALID", 64'(out_valid), 64'(0));
        chk("midrst_o_RESULT", 64'(result), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        drain(6);
        // Table reads zero after reset.
        tick(1'b1, mkvec(1'b1, 1'b0, 25'sd60000, '0), 1'b1, 1'b0, '0, '0, acc_f);
        tick(1'b1, mkvec(1'b0, 1'b1, -25'sd5000, 4'd1), 1'b1, 1'b0, '0, '0, acc_f);
        drain(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsdmnist_requant.md
# dsdmnist_requant

Parametrised, pipelined requantisation stage for the MNIST accelerator. It takes a signed MAC accumulator value plus a channel index and applies an optional ReLU. It then multiplies by a per-channel fixed-point scale constant held in an internal writable table, rounds, and saturates to a signed or unsigned OUT_W-bit activation. It sits between the MAC array and the activation buffer, with valid/ready flow control on both sides.

## Interface
- ACC_W, 25, accumulator width (signed)
- K_W, 33, scale constant width (signed, FRAC fractional bits)
- FRAC, 32, fractional bits of the constant
- OUT_W, 8, result width
- NCH, 16, constant table depth (channels); CH_W = $clog2(NCH)
- i_CLK  in  1  clock, all logic on rising edge
- i_RST_n  in  1  asynchronous, active-low reset
- i_K_WR  in  1  table write strobe
- i_K_ADDR  in  CH_W  table write address
- i_K_DATA  in  K_W  constant to write (signed QK_W-FRAC.FRAC)
- i_RELU_EN  in  1  1 = clamp negative accumulators to 0
- i_SIGNED_OUT  in  1  1 = signed output range, 0 = unsigned
- i_VALID  in  1  input sample valid
- o_READY  out  1  block accepts sample this cycle
- i_ACC  in  ACC_W  signed accumulator
- i_CH  in  CH_W  channel index selecting the constant
- o_VALID  out  1  result valid
- i_READY  in  1  downstream accepts result
- o_RESULT  out  OUT_W  requantised result (two's complement if signed mode)
- o_SAT  out  1  result was clipped (qualified by o_VALID)

## Operation
- Three stages, each with its own valid bit: S1 = ReLU and constant lookup, S2 = ACC_W+K_W signed multiply (DSP-mapped register), S3 = round and clip into the output register.
- Global advance enable `adv = ~o_VALID | i_READY`. All stages shift together when adv=1 and hold when adv=0. o_READY = adv.
- Input transfer on i_VALID & o_READY. Output transfer on o_VALID & i_READY.
- ReLU: when i_RELU_EN=1 and i_ACC<0, the S1 value is 0. Otherwise the S1 value is i_ACC.
- Rounding: r = (prod + 2^(FRAC-1)) >>> FRAC, arithmetic shift, so halves round toward +inf. r is held full width with no truncation before the clip.
- Clip in signed mode: [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Clip in unsigned mode: [0, 2^OUT_W-1].
- o_SAT = 1 when r lay outside the selected range.
- i_RELU_EN and i_SIGNED_OUT are sampled with each sample in S1 and carried down the pipe. A mode change never affects samples already in flight.
- Constant table: NCH x K_W registers.
  - A write on i_K_WR updates the entry at the clock edge.
  - A sample entering S1 on the same cycle as a write to its channel uses the old value.
- Writes are accepted regardless of adv.

## Timing
- Latency: 3 cycles from input transfer to o_VALID with no backpressure. Throughput is 1 sample/cycle.
- Reset (async assert, sync release internally not required): all valid bits 0, o_VALID=0, o_RESULT=0, o_SAT=0, all table entries 0. o_READY=1 from the first cycle after reset.
- Backpressure: while i_READY=0 and o_VALID=1, the pipe holds up to 3 samples and o_READY=0. o_RESULT and o_SAT must stay stable until the transfer.
- Bubbles (i_VALID=0) propagate as invalid slots. They do not stall the pipe.
- Reset asserted mid-operation drops all in-flight samples. No result appears after release for any sample accepted before reset.
- Simultaneous output transfer and input transfer in the same cycle is legal, and no slot is lost.

## Structure
- Package dsdmnist_pkg holds:
  - default parameter constants: ACC_W, K_W, FRAC, OUT_W, NCH;
  - the layer scale constants K1 = 33'sh0_00A3_E3B6 and K2 = 33'sh0_0230_FB0F;
  - a round-and-clip function parameterised by width, used by the RTL and by the bench model.
- Sub-module dsdmnist_ktable contains the constant register file: write port, asynchronous read, reset to 0.

## Test plan
- Load K1 into ch0, ReLU on, unsigned; feed acc=1000, 50800, 60000 -> results 3, 127, 150, each 3 cycles after acceptance, o_SAT=0 throughout.
- Same K1, signed mode; acc=60000 -> result 127, o_SAT=1. ReLU on, acc=-1000 -> result 0, o_SAT=0.
- ReLU off, signed, K1; acc=-1000 -> result -3 (8'hFD). acc=-12744704 -> result -128, o_SAT=1.
- Load K1 into ch0 and K2 into ch1; stream alternating ch0/ch1 with acc=1000 -> results 3, 9 alternating. Write ch1 on the same cycle a ch1 sample enters -> that sample uses the old constant.
- Stream 8 samples with i_READY=0 for 5 cycles mid-stream -> o_READY drops once 3 samples are held, outputs stay stable, all 8 results arrive in order with no duplicates.
- Assert i_RST_n=0 with 3 samples in flight -> o_VALID=0 immediately, table reads 0, and no stale results after release.
